// File: rtl/pc_npc_btb.sv
// rtl/pc_npc_btb.sv - PC register with direct-mapped BTB fetch prediction and EX-stage redirect
//
// Purpose: holds the fetch PC. It predicts the next PC from a direct-mapped branch target
// buffer that uses 2-bit saturating counters. It resolves EX-stage control flow, updates
// the BTB, and raises redirect on a misprediction.
// Optional build macro: PC_BP_STATS_EN adds the branch and misprediction statistics counters.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   stall                      hold PC; ignored when redirect is high
//   pc                         current fetch PC
//   pred_taken, pred_npc       fetch-time prediction for pc
//   ex_valid, ex_pc, ex_br,    EX-stage resolution inputs
//   ex_jmp, ex_taken,
//   ex_target, ex_pred_npc
//   redirect                   misprediction; flush younger stages this cycle
//   stat_branches              (PC_BP_STATS_EN) resolved br/jmp count, saturating
//   stat_mispred               (PC_BP_STATS_EN) redirect count, saturating

module pc_npc_btb #(
    parameter int          XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_npc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_br,
    input  logic            ex_jmp,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic            redirect
`ifdef PC_BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] jmp_q;
    logic [TW-1:0]          tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]  l_idx;
    logic [TW-1:0]   l_tag;
    logic            l_hit;
    logic [XLEN-1:0] pc_plus4;

    assign l_idx      = pc[IDX+1:2];
    assign l_tag      = pc[XLEN-1:IDX+2];
    assign l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pc_plus4   = pc + XLEN'(4);
    assign pred_taken = l_hit && (jmp_q[l_idx] || ctr_q[l_idx][1]);
    assign pred_npc   = pred_taken ? tgt_q[l_idx] : pc_plus4;

    // EX-side resolution
    logic [IDX-1:0]  e_idx;
    logic [TW-1:0]   e_tag;
    logic            e_hit;
    logic            e_cf;
    logic [XLEN-1:0] actual_npc;

    assign e_idx      = ex_pc[IDX+1:2];
    assign e_tag      = ex_pc[XLEN-1:IDX+2];
    assign e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_cf       = ex_br || ex_jmp;
    assign actual_npc = ex_taken ? ex_target : (ex_pc + XLEN'(4));
    // Every valid EX instruction is checked, so a non-branch that was fetched through a
    // stale BTB alias also redirects.
    assign redirect   = ex_valid && (actual_npc != ex_pred_npc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= actual_npc;
        end else if (!stall) begin
            pc <= pred_npc;
        end
    end

    // BTB update is independent of stall. Lookup reads the pre-edge contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (ex_valid && e_cf) begin
            if (e_hit) begin
                if (ex_taken) begin
                    tgt_q[e_idx] <= ex_target;
                    jmp_q[e_idx] <= ex_jmp;
                    if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
                end else begin
                    if (ctr_q[e_idx] != 2'b00) ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= ex_target;
                jmp_q[e_idx]   <= ex_jmp;
                ctr_q[e_idx]   <= 2'b10;
            end
        end else if (ex_valid && e_hit) begin
            // A non-control-flow instruction owns this entry's tag, so the entry is stale.
            valid_q[e_idx] <= 1'b0;
        end
    end

`ifdef PC_BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (ex_valid && e_cf && (stat_branches != 32'hFFFF_FFFF))
                stat_branches <= stat_branches + 32'd1;
            if (redirect && (stat_mispred != 32'hFFFF_FFFF))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_npc_btb.sv
// tb/tb_pc_npc_btb.sv - self-checking bench for pc_npc_btb against a behavioural model

module tb_pc_npc_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_br;
    logic        ex_jmp;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_npc;
    logic        redirect;
`ifdef PC_BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    pc_npc_btb dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pc(pc), .pred_taken(pred_taken), .pred_npc(pred_npc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br(ex_br), .ex_jmp(ex_jmp),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_npc(ex_pred_npc),
        .redirect(redirect)
`ifdef PC_BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per BTB slot, plain integers.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    bit          m_jmp   [16];
    int          m_ctr   [16];
    int unsigned m_pc;
    int unsigned m_branches;
    int unsigned m_mispred;

    function automatic int unsigned midx(int unsigned a);
        return (a / 4) % 16;
    endfunction

    function automatic bit m_hit(int unsigned a);
        return m_valid[midx(a)] && (m_tag[midx(a)] == a / 64);
    endfunction

    function automatic bit m_ptaken(int unsigned a);
        return m_hit(a) && (m_jmp[midx(a)] || m_ctr[midx(a)] >= 2);
    endfunction

    function automatic int unsigned m_pnpc(int unsigned a);
        return m_ptaken(a) ? m_tgt[midx(a)] : a + 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jmp[i] = 0; m_ctr[i] = 1;
        end
        m_pc = 0; m_branches = 0; m_mispred = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_br = 0; ex_jmp = 0; ex_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_npc = 0;
    endtask

    // Check outputs against the model, then clock once and advance the model.
    task automatic step();
        int unsigned a_npc, nxt, i;
        bit exp_redir, cf, hit;
        #1;
        a_npc     = ex_taken ? ex_target : ex_pc + 4;
        exp_redir = ex_valid && (a_npc != ex_pred_npc);
        chk("pc", pc, m_pc);
        chk("pred_taken", 32'(pred_taken), 32'(m_ptaken(m_pc)));
        chk("pred_npc", pred_npc, m_pnpc(m_pc));
        chk("redirect", 32'(redirect), 32'(exp_redir));
`ifdef PC_BP_STATS_EN
        chk("stat_branches", stat_branches, m_branches);
        chk("stat_mispred", stat_mispred, m_mispred);
`endif
        nxt = exp_redir ? a_npc : (stall ? m_pc : m_pnpc(m_pc));
        i   = midx(ex_pc);
        hit = m_hit(ex_pc);
        cf  = ex_br || ex_jmp;
        @(posedge clk);
        m_pc = nxt;
        if (ex_valid && cf) begin
            if (m_branches != 32'hFFFF_FFFF) m_branches++;
            if (hit && ex_taken) begin
                m_tgt[i] = ex_target; m_jmp[i] = ex_jmp;
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else if (ex_taken) begin
                m_valid[i] = 1; m_tag[i] = ex_pc / 64; m_tgt[i] = ex_target;
                m_jmp[i] = ex_jmp; m_ctr[i] = 2;
            end
        end else if (ex_valid && hit) begin
            m_valid[i] = 0;
        end
        if (exp_redir && m_mispred != 32'hFFFF_FFFF) m_mispred++;
        #1;
    endtask

    // Use a wrongly predicted non-branch to steer fetch to address a.
    task automatic redirect_to(int unsigned a);
        ex_valid = 1; ex_br = 0; ex_jmp = 0; ex_taken = 0;
        ex_pc = a - 4; ex_pred_npc = a ^ 32'h100; ex_target = 0;
        step();
        clear_ex();
        #1;
    endtask

    task automatic set_br(int unsigned a, bit tk, int unsigned tgt, int unsigned pn);
        ex_valid = 1; ex_br = 1; ex_jmp = 0; ex_taken = tk;
        ex_pc = a; ex_target = tgt; ex_pred_npc = pn;
    endtask

    initial begin
        rst = 1; stall = 0;
        clear_ex();
        model_reset();
        #12;
        chk("reset_pc", pc, 32'h0);
        chk("reset_pred_taken", 32'(pred_taken), 32'h0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        m_pc = 32'h4;

        // 1: idle sequential fetch
        for (int k = 0; k < 4; k++) step();
        chk("t1_pc_seq", pc, 32'h14);

        // 2: taken branch at 0x8 predicted fall-through
        set_br(32'h8, 1, 32'h40, 32'hC);
        #1 chk("t2_redirect", 32'(redirect), 32'h1);
        step();
        clear_ex();
        chk("t2_pc", pc, 32'h40);
        redirect_to(32'h8);
        chk("t2_pred_taken", 32'(pred_taken), 32'h1);
        chk("t2_pred_npc", pred_npc, 32'h40);
        step();

        // 3: two not-taken resolutions decay the counter
        set_br(32'h8, 0, 32'h40, 32'h40);
        step();
        chk("t3_pc_after_redirect", pc, 32'hC);
        set_br(32'h8, 0, 32'h40, 32'hC);
        step();
        clear_ex();
        redirect_to(32'h8);
        chk("t3_pred_taken", 32'(pred_taken), 32'h0);
        chk("t3_pred_npc", pred_npc, 32'hC);

        // 4: redirect overrides stall; stall alone holds
        stall = 1;
        ex_valid = 1; ex_pc = 32'h100; ex_pred_npc = 32'h0;
        step();
        clear_ex();
        chk("t4_redirect_vs_stall", pc, 32'h104);
        step();
        chk("t4_stall_hold", pc, 32'h104);
        stall = 0;

        // 5: alias at 0x48 replaces the entry for 0x8
        set_br(32'h48, 1, 32'h80, 32'h4C);
        step();
        clear_ex();
        chk("t5_pc", pc, 32'h80);
        redirect_to(32'h8);
        chk("t5_alias_miss", pred_npc, 32'hC);

        // 6: PC wrap
        redirect_to(32'hFFFF_FFFC);
        chk("t6_wrap_npc", pred_npc, 32'h0);
        step();
        chk("t6_wrap_pc", pc, 32'h0);

        // Random traffic with a mix of branches, jumps, non-branches and stalls.
        for (int n = 0; n < 400; n++) begin
            int unsigned kind;
            stall    = ($urandom % 5) == 0;
            ex_valid = ($urandom % 3) != 0;
            kind     = $urandom % 4;
            ex_br    = (kind == 1) || (kind == 3);
            ex_jmp   = (kind >= 2);
            ex_pc    = ($urandom_range(0, 23) << 2) + (($urandom % 4 == 0) ? 32'h40 : 32'h0);
            ex_taken = ex_jmp ? 1'b1 : ($urandom % 2 == 1);
            if (kind == 0) ex_taken = 0;
            ex_target = $urandom_range(0, 63) << 2;
            case ($urandom % 4)
                0: ex_pred_npc = $urandom_range(0, 63) << 2;
                1: ex_pred_npc = ex_pc + 4;
                default: ex_pred_npc = m_pnpc(ex_pc);
            endcase
            step();
        end
        clear_ex();
        stall = 0;

        // Asynchronous reset mid-cycle empties the BTB immediately.
        redirect_to(32'h20);
        #2 rst = 1;
        #1 chk("async_reset_pc", pc, 32'h0);
        chk("async_reset_pred", 32'(pred_taken), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        m_pc = 32'h4;
        for (int k = 0; k < 4; k++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
